// File: rtl/tff_pkg.sv
// Shared types and defaults for the T flip-flop input path.
// Holds the toggle-pulse FSM state encoding and the default timing constants.
package tff_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int REPEAT_DELAY_DEF    = 64;
    localparam int REPEAT_PERIOD_DEF   = 16;
    localparam int CNT_W_DEF           = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous levels entering the clk domain.
// WIDTH bits are synchronised independently; use only for quasi-static levels.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/toggle_pulse_gen.sv
// Push-button front end for the T flip-flop: synchronise, debounce and emit
// single-cycle toggle pulses on t, with optional auto-repeat while held.
module toggle_pulse_gen
    import tff_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_in,
    input  logic enable,
    output logic t,
    output logic btn_level,
    output logic bouncing
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
        $fatal(1, "toggle_pulse_gen: DEBOUNCE_CYCLES out of range 2..65535");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_rep
        $fatal(1, "toggle_pulse_gen: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end
    if (CNT_W < 1 || CNT_W > 32 ||
        (64'd1 << CNT_W) <= 64'(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD))) begin : g_bad_w
        $fatal(1, "toggle_pulse_gen: CNT_W too narrow for the configured counts");
    end

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             btn_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rcnt;
    logic             rep_first;
    logic             armed;

    logic             db_done;
    logic [CNT_W-1:0] cnt_inc;
    logic             rep_hit;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_btn (
        .clk  (clk),
        .rstn (rstn),
        .d    (btn_in),
        .q    (btn_s)
    );

    // Debounce counter saturates at its terminal value instead of wrapping.
    assign db_done = (cnt == DB_LAST);
    assign cnt_inc = db_done ? cnt : cnt + 1'b1;
    assign rep_hit = (REPEAT_EN != 0) && (rcnt == (rep_first ? DLY_LAST : PER_LAST));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            rcnt      <= '0;
            rep_first <= 1'b1;
            armed     <= 1'b0;
            t         <= 1'b0;
            btn_level <= 1'b0;
            bouncing  <= 1'b0;
        end else begin
            t        <= 1'b0;
            bouncing <= (btn_s != btn_level);
            case (state)
                IDLE: begin
                    // After reset the button must be seen debounced low before a
                    // press is accepted, so a held button never fires on release.
                    if (!armed) begin
                        if (btn_s) begin
                            cnt <= '0;
                        end else if (db_done) begin
                            armed <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else if (btn_s) begin
                        state <= PRESS_CHK;
                        cnt   <= cnt_inc;
                    end else begin
                        cnt <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (db_done) begin
                        state     <= HELD;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                        t         <= enable;
                        rcnt      <= '0;
                        rep_first <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state <= REL_CHK;
                        cnt   <= cnt_inc;
                    end else begin
                        cnt <= '0;
                        if (REPEAT_EN != 0) begin
                            if (rep_hit) begin
                                t         <= enable;
                                rcnt      <= '0;
                                rep_first <= 1'b0;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                    end
                end
                REL_CHK: begin
                    // Repeat counter holds here so a release bounce only delays repeats.
                    if (btn_s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (db_done) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Bench for toggle_pulse_gen: two instances (repeat off / on) share btn_in,
// expected pulse cycles are queued at stimulus time and matched on t.
module tb_toggle_pulse_gen;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 4;
    localparam int CW = 8;

    typedef struct {
        int   len;
        logic en;
        logic pulse;
        logic lvl;
    } vec_t;

    logic clk, rstn, btn_in, en0, en1;
    logic t0, lvl0, bnc0, t1, lvl1, bnc1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   q0[$];
    int   q1[$];
    logic t0_prev = 1'b0;
    logic t1_prev = 1'b0;
    logic bnc_seen = 1'b0;
    logic lvl_seen = 1'b0;
    vec_t vecs[6];

    toggle_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(RD),
                       .REPEAT_PERIOD(RP), .CNT_W(CW)) dut0 (
        .clk(clk), .rstn(rstn), .btn_in(btn_in), .enable(en0),
        .t(t0), .btn_level(lvl0), .bouncing(bnc0));

    toggle_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD),
                       .REPEAT_PERIOD(RP), .CNT_W(CW)) dut1 (
        .clk(clk), .rstn(rstn), .btn_in(btn_in), .enable(en1),
        .t(t1), .btn_level(lvl1), .bouncing(bnc1));

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboards: every t pulse must match the head of its expected queue.
    always @(negedge clk) begin
        while (q0.size() != 0 && q0[0] < cyc) begin
            checks++; errors++;
            $display("FAIL t0_missed: t0=0 at cycle %0d, expected 1", q0[0]);
            void'(q0.pop_front());
        end
        if (t0) begin
            checks++;
            if (q0.size() != 0 && q0[0] == cyc) void'(q0.pop_front());
            else begin
                errors++;
                $display("FAIL t0_pulse: t0=1 at cycle %0d, expected 0", cyc);
            end
            checks++;
            if (t0_prev) begin
                errors++;
                $display("FAIL t0_width: t0=1 at cycles %0d and %0d, expected single cycle", cyc - 1, cyc);
            end
        end
        t0_prev = t0;
    end

    always @(negedge clk) begin
        while (q1.size() != 0 && q1[0] < cyc) begin
            checks++; errors++;
            $display("FAIL t1_missed: t1=0 at cycle %0d, expected 1", q1[0]);
            void'(q1.pop_front());
        end
        if (t1) begin
            checks++;
            if (q1.size() != 0 && q1[0] == cyc) void'(q1.pop_front());
            else begin
                errors++;
                $display("FAIL t1_pulse: t1=1 at cycle %0d, expected 0", cyc);
            end
            checks++;
            if (t1_prev) begin
                errors++;
                $display("FAIL t1_width: t1=1 at cycles %0d and %0d, expected single cycle", cyc - 1, cyc);
            end
        end
        t1_prev = t1;
        if (bnc0) bnc_seen = 1'b1;
        if (lvl0) lvl_seen = 1'b1;
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_both(input int c);
        q0.push_back(c);
        q1.push_back(c);
    endtask

    initial begin
        int c;
        vecs[0] = '{len: 1,  en: 1'b1, pulse: 1'b0, lvl: 1'b0};
        vecs[1] = '{len: 3,  en: 1'b1, pulse: 1'b0, lvl: 1'b0};
        vecs[2] = '{len: 4,  en: 1'b1, pulse: 1'b1, lvl: 1'b1};
        vecs[3] = '{len: 10, en: 1'b1, pulse: 1'b1, lvl: 1'b1};
        vecs[4] = '{len: 6,  en: 1'b0, pulse: 1'b0, lvl: 1'b1};
        vecs[5] = '{len: 2,  en: 1'b0, pulse: 1'b0, lvl: 1'b0};

        rstn = 1'b0; btn_in = 1'b0; en0 = 1'b1; en1 = 1'b1;
        #3;
        check("rst_t0", t0, 1'b0);
        check("rst_lvl0", lvl0, 1'b0);
        check("rst_bnc0", bnc0, 1'b0);
        check("rst_t1", t1, 1'b0);
        check("rst_lvl1", lvl1, 1'b0);
        #12 rstn = 1'b1;
        tick(10);

        // Press lengths around the debounce threshold; release is part of each vector.
        foreach (vecs[i]) begin
            en0 = vecs[i].en; en1 = vecs[i].en;
            btn_in = 1'b1; c = cyc;
            if (vecs[i].pulse) push_both(c + D + 2);
            for (int j = 1; j <= 24; j++) begin
                @(negedge clk);
                if (j == vecs[i].len) btn_in = 1'b0;
                if (j == D + 1) check($sformatf("v%0d_lvl_pre", i), lvl0, 1'b0);
                if (j == D + 2) begin
                    check($sformatf("v%0d_lvl0", i), lvl0, vecs[i].lvl);
                    check($sformatf("v%0d_lvl1", i), lvl1, vecs[i].lvl);
                end
            end
            check($sformatf("v%0d_lvl_end", i), lvl0, 1'b0);
            check($sformatf("v%0d_bnc_end", i), bnc0, 1'b0);
        end

        // Bounce rejection.
        en0 = 1'b1; en1 = 1'b1; bnc_seen = 1'b0; lvl_seen = 1'b0;
        btn_in = 1'b1; tick(2); btn_in = 1'b0; tick(2);
        btn_in = 1'b1; tick(2); btn_in = 1'b0; tick(12);
        check("bounce_seen", bnc_seen, 1'b1);
        check("bounce_lvl", lvl_seen, 1'b0);
        check("bounce_settle", bnc0, 1'b0);

        // Release bounce from HELD.
        en1 = 1'b0;
        btn_in = 1'b1; c = cyc; q0.push_back(c + D + 2);
        tick(10); btn_in = 1'b0; tick(2); btn_in = 1'b1; tick(5);
        check("rb_lvl_held", lvl0, 1'b1);
        btn_in = 1'b0; tick(D + 1);
        check("rb_lvl_pre", lvl0, 1'b1);
        tick(1);
        check("rb_lvl_fall0", lvl0, 1'b0);
        check("rb_lvl_fall1", lvl1, 1'b0);
        tick(10);

        // Auto-repeat.
        en0 = 1'b1; en1 = 1'b1;
        btn_in = 1'b1; c = cyc;
        push_both(c + D + 2);
        q1.push_back(c + D + 2 + RD);
        q1.push_back(c + D + 2 + RD + RP);
        q1.push_back(c + D + 2 + RD + 2 * RP);
        tick(20); btn_in = 1'b0; tick(D + 1);
        check("ar_lvl_pre", lvl1, 1'b1);
        tick(1);
        check("ar_lvl_fall", lvl1, 1'b0);
        tick(14);

        // enable gating: dropped pulses, raise while held, re-press.
        en0 = 1'b0; en1 = 1'b0;
        btn_in = 1'b1; c = cyc;
        tick(8);
        check("en_lvl_held", lvl0, 1'b1);
        tick(1); en0 = 1'b1;
        tick(6); en1 = 1'b1; q1.push_back(c + D + 2 + RD + RP);
        tick(5); btn_in = 1'b0; q1.push_back(c + D + 2 + RD + 2 * RP);
        tick(10);
        check("en_lvl_rel", lvl0, 1'b0);
        btn_in = 1'b1; c = cyc; push_both(c + D + 2);
        tick(6); btn_in = 1'b0; tick(16);

        // Reset while held: outputs clear at once, no pulse until re-armed.
        btn_in = 1'b1; c = cyc; push_both(c + D + 2);
        tick(D + 2);
        #2 rstn = 1'b0;
        #1;
        check("mr_t0", t0, 1'b0);
        check("mr_t1", t1, 1'b0);
        check("mr_lvl0", lvl0, 1'b0);
        check("mr_lvl1", lvl1, 1'b0);
        tick(3); rstn = 1'b1;
        tick(15);
        check("mr_held_lvl", lvl0, 1'b0);
        btn_in = 1'b0; tick(2); btn_in = 1'b1; tick(12);
        check("mr_short_rel_lvl", lvl0, 1'b0);
        btn_in = 1'b0; tick(8);
        btn_in = 1'b1; c = cyc; push_both(c + D + 2);
        tick(D + 2);
        check("mr_repress_lvl", lvl0, 1'b1);
        btn_in = 1'b0; tick(16);
        check("mr_end_lvl", lvl0, 1'b0);

        tick(4);
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL q0_drain: %0d pulses outstanding, expected 0", q0.size());
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL q1_drain: %0d pulses outstanding, expected 0", q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
